// File: rtl/shift_reg_universal.sv
// shift_reg_universal: enable-gated WIDTH-bit universal register.
// Supports parallel load, logical shifts, rotates, arithmetic shift right and clear,
// plus a saturating count of shift/rotate operations with a registered done flag.
//
// Ports:
//   clk     - clock, all state updates on the rising edge
//   reset   - synchronous active-low reset
//   en      - clock enable, 0 holds all state
//   mode    - operation select (HOLD, LOAD, SHL, SHR, ROL, ROR, ASR, CLEAR)
//   d       - parallel load data
//   sin_l   - serial input entering the MSB on SHR
//   sin_r   - serial input entering the LSB on SHL
//   q       - register contents
//   sout_l  - q[WIDTH-1]
//   sout_r  - q[0]
//   cnt     - shifts since last load/clear/reset, saturating at WIDTH
//   done    - 1 exactly when cnt == WIDTH
module shift_reg_universal #(
   parameter int unsigned          WIDTH     = 8,
   parameter logic [WIDTH-1:0]     RESET_VAL = '0,
   localparam int unsigned         CW        = $clog2(WIDTH + 1)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             en,
   input  logic [2:0]       mode,
   input  logic [WIDTH-1:0] d,
   input  logic             sin_l,
   input  logic             sin_r,
   output logic [WIDTH-1:0] q,
   output logic             sout_l,
   output logic             sout_r,
   output logic [CW-1:0]    cnt,
   output logic             done
);

   typedef enum logic [2:0] {
      ModeHold  = 3'b000,
      ModeLoad  = 3'b001,
      ModeShl   = 3'b010,
      ModeShr   = 3'b011,
      ModeRol   = 3'b100,
      ModeRor   = 3'b101,
      ModeAsr   = 3'b110,
      ModeClear = 3'b111
   } mode_e;

   localparam logic [CW-1:0] CntMax = CW'(WIDTH);

   logic [WIDTH-1:0] q_q, q_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic             done_q, done_d;
   logic             shift;

   always_comb begin
      q_d   = q_q;
      cnt_d = cnt_q;
      shift = 1'b0;
      unique case (mode_e'(mode))
         ModeHold:  ;
         ModeLoad: begin
            q_d   = d;
            cnt_d = '0;
         end
         ModeShl: begin
            q_d   = {q_q[WIDTH-2:0], sin_r};
            shift = 1'b1;
         end
         ModeShr: begin
            q_d   = {sin_l, q_q[WIDTH-1:1]};
            shift = 1'b1;
         end
         ModeRol: begin
            q_d   = {q_q[WIDTH-2:0], q_q[WIDTH-1]};
            shift = 1'b1;
         end
         ModeRor: begin
            q_d   = {q_q[0], q_q[WIDTH-1:1]};
            shift = 1'b1;
         end
         ModeAsr: begin
            q_d   = {q_q[WIDTH-1], q_q[WIDTH-1:1]};
            shift = 1'b1;
         end
         ModeClear: begin
            q_d   = RESET_VAL;
            cnt_d = '0;
         end
         default: ;
      endcase
      // Counter saturates; q keeps shifting beyond it.
      if (shift && (cnt_q != CntMax)) begin
         cnt_d = cnt_q + 1'b1;
      end
      // done tracks the next count so it rises with cnt, not a cycle later.
      done_d = (cnt_d == CntMax);
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         q_q    <= RESET_VAL;
         cnt_q  <= '0;
         done_q <= 1'b0;
      end else if (en) begin
         q_q    <= q_d;
         cnt_q  <= cnt_d;
         done_q <= done_d;
      end
   end

   assign q      = q_q;
   assign sout_l = q_q[WIDTH-1];
   assign sout_r = q_q[0];
   assign cnt    = cnt_q;
   assign done   = done_q;

endmodule

// File: tb/tb_shift_reg_universal.sv
// Testbench for shift_reg_universal (WIDTH=8, RESET_VAL=8'hA5): directed steps from the
// test plan followed by random operations, all checked against an arithmetic reference model.
module tb_shift_reg_universal;

   localparam int unsigned W  = 8;
   localparam logic [7:0]  RV = 8'hA5;

   logic       clk = 1'b0;
   logic       reset, en, sin_l, sin_r;
   logic [2:0] mode;
   logic [7:0] d;
   logic [7:0] q;
   logic       sout_l, sout_r, done;
   logic [3:0] cnt;

   int passed = 0;
   int total  = 0;

   // Reference model state
   logic [7:0] mq;
   int         mc;

   shift_reg_universal #(
      .WIDTH     (W),
      .RESET_VAL (RV)
   ) dut (
      .clk    (clk),
      .reset  (reset),
      .en     (en),
      .mode   (mode),
      .d      (d),
      .sin_l  (sin_l),
      .sin_r  (sin_r),
      .q      (q),
      .sout_l (sout_l),
      .sout_r (sout_r),
      .cnt    (cnt),
      .done   (done)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) passed++;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
   endtask

   // Apply one operation across one rising edge, advance the model, then compare.
   task automatic step(input logic r, input logic e, input logic [2:0] m, input logic [7:0] dd,
                       input logic sl, input logic sr);
      bit sh;
      reset = r; en = e; mode = m; d = dd; sin_l = sl; sin_r = sr;
      @(posedge clk);
      sh = 1'b0;
      if (!r) begin
         mq = RV;
         mc = 0;
      end else if (e) begin
         case (m)
            3'd0: ;
            3'd1: begin mq = dd; mc = 0; end
            3'd2: begin mq = 8'((mq * 2) + 8'(sr)); sh = 1'b1; end
            3'd3: begin mq = 8'((mq / 2) + (sl ? 128 : 0)); sh = 1'b1; end
            3'd4: begin mq = 8'((mq * 2) + (mq / 128)); sh = 1'b1; end
            3'd5: begin mq = 8'((mq / 2) + ((mq % 2) * 128)); sh = 1'b1; end
            3'd6: begin mq = 8'($signed(mq) >>> 1); sh = 1'b1; end
            default: begin mq = RV; mc = 0; end
         endcase
         if (sh && mc < int'(W)) mc = mc + 1;
      end
      #1;
      check("q", 32'(q), 32'(mq));
      check("cnt", 32'(cnt), 32'(mc));
      check("done", 32'(done), 32'(mc == int'(W)));
      check("sout_l", 32'(sout_l), 32'(mq / 128));
      check("sout_r", 32'(sout_r), 32'(mq % 2));
   endtask

   initial begin
      logic [7:0] exp_sout;
      logic [7:0] sin_seq;
      mq = 8'h00;
      mc = 0;
      reset = 1'b0; en = 1'b1; mode = 3'd1; d = 8'hFF; sin_l = 1'b0; sin_r = 1'b0;

      // Reset held over a LOAD
      step(0, 1, 3'd1, 8'hFF, 0, 0);
      step(0, 1, 3'd1, 8'hFF, 0, 0);
      check("rst_q", 32'(q), 32'h A5);
      check("rst_cnt", 32'(cnt), 32'd0);
      check("rst_done", 32'(done), 32'd0);

      // Load then serialise out through sout_l
      exp_sout = 8'b1011_0100;
      step(1, 1, 3'd1, 8'hB4, 0, 0);
      check("ser_sout_l0", 32'(sout_l), 32'(exp_sout[7]));
      for (int i = 1; i <= 8; i++) begin
         step(1, 1, 3'd2, 8'h00, 0, 0);
         if (i < 8) check("ser_sout_l", 32'(sout_l), 32'(exp_sout[7-i]));
      end
      check("ser_q", 32'(q), 32'h00);
      check("ser_cnt", 32'(cnt), 32'd8);
      check("ser_done", 32'(done), 32'd1);
      step(1, 1, 3'd2, 8'h00, 0, 0);
      check("sat_cnt", 32'(cnt), 32'd8);
      check("sat_done", 32'(done), 32'd1);

      // Serial in via SHR
      sin_seq = 8'b1100_1010;
      step(1, 1, 3'd7, 8'h00, 0, 0);
      for (int i = 0; i < 8; i++) step(1, 1, 3'd3, 8'h00, sin_seq[7-i], 0);
      check("sin_q", 32'(q), 32'h53);
      check("sin_done", 32'(done), 32'd1);

      // Rotates and arithmetic shift
      step(1, 1, 3'd1, 8'h81, 0, 0);
      step(1, 1, 3'd4, 8'h00, 0, 0); check("rol_q", 32'(q), 32'h03);
      step(1, 1, 3'd5, 8'h00, 0, 0); check("ror_q", 32'(q), 32'h81);
      step(1, 1, 3'd6, 8'h00, 1, 0); check("asr1_q", 32'(q), 32'hC0);
      step(1, 1, 3'd6, 8'h00, 0, 0); check("asr2_q", 32'(q), 32'hE0);
      check("rot_cnt", 32'(cnt), 32'd4);

      // Enable gating
      step(1, 1, 3'd1, 8'h3C, 0, 0);
      for (int i = 0; i < 3; i++) begin
         step(1, 0, 3'd2, 8'h00, 0, 1);
         check("gate_q", 32'(q), 32'h3C);
         check("gate_cnt", 32'(cnt), 32'd0);
      end
      step(1, 1, 3'd2, 8'h00, 0, 1);
      check("en_shl_q", 32'(q), 32'h79);
      check("en_shl_cnt", 32'(cnt), 32'd1);

      // Reset mid-shift
      for (int i = 0; i < 5; i++) step(1, 1, 3'd2, 8'h00, 0, 1);
      step(0, 1, 3'd2, 8'h00, 0, 1);
      check("midrst_q", 32'(q), 32'hA5);
      check("midrst_cnt", 32'(cnt), 32'd0);
      step(1, 1, 3'd2, 8'h00, 0, 1);
      check("post_rst_cnt", 32'(cnt), 32'd1);

      // LOAD and CLEAR at cnt == WIDTH-1 win over the pending saturation
      for (int i = 0; i < 6; i++) step(1, 1, 3'd4, 8'h00, 0, 0);
      step(1, 1, 3'd1, 8'h5A, 0, 0);
      check("ld_win_cnt", 32'(cnt), 32'd0);
      check("ld_win_done", 32'(done), 32'd0);
      for (int i = 0; i < 7; i++) step(1, 1, 3'd5, 8'h00, 0, 0);
      step(1, 1, 3'd7, 8'h00, 0, 0);
      check("clr_win_q", 32'(q), 32'hA5);
      check("clr_win_done", 32'(done), 32'd0);

      // Random operations; loads/clears kept rare so saturation is reached often
      for (int i = 0; i < 400; i++) begin
         logic [2:0] m;
         m = 3'($urandom_range(2, 6));
         if ($urandom_range(0, 15) == 0) m = 3'($urandom_range(0, 7));
         step(($urandom_range(0, 49) != 0), ($urandom_range(0, 7) != 0), m,
              8'($urandom), 1'($urandom), 1'($urandom));
      end

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: observed no finish expected finish");
      $fatal(1, "timeout");
   end

endmodule

// File: doc/shift_reg_universal.md
# shift_reg_universal

Parametrised, enable-gated universal register that extends the single-bit synchronous D flip-flop to a WIDTH-bit word. It supports parallel load, logical/arithmetic shifts, rotates and clear, plus a saturating shift counter with a `done` flag. It sits in the register/serialiser layer as the common building block for parallel-to-serial and serial-to-parallel conversion.

## Interface
- `WIDTH`, 8, word width in bits; must be ≥ 2.
- `RESET_VAL`, 0, value loaded into `q` by reset and by the CLEAR mode; it is WIDTH bits wide.
- `clk`  input  1  single clock; all state updates on its rising edge.
- `reset`  input  1  synchronous, active-low reset, sampled only on the rising edge of `clk`.
- `en`  input  1  clock enable; 0 holds all state.
- `mode`  input  3  operation select; encodings are listed under Operation.
- `d`  input  WIDTH  parallel load data.
- `sin_l`  input  1  serial input entering the MSB on shift-right.
- `sin_r`  input  1  serial input entering the LSB on shift-left.
- `q`  output  WIDTH  register contents.
- `sout_l`  output  1  equals `q[WIDTH-1]`, driven combinationally from the register.
- `sout_r`  output  1  equals `q[0]`, driven combinationally from the register.
- `cnt`  output  $clog2(WIDTH+1)  number of shift/rotate operations since the last load, clear or reset; saturates at WIDTH.
- `done`  output  1  registered flag, 1 exactly when `cnt == WIDTH`.

## Operation
- Priority on each rising edge is: `reset==0`, then `en==0`, then `mode`.
- Reset state:
  - `q = RESET_VAL`, `cnt = 0`, `done = 0`.
  - `sout_l`/`sout_r` follow from `RESET_VAL`.
  - Reset overrides `en` and `mode`.
- `en==0`: `q`, `cnt` and `done` all hold, regardless of `mode`.
- Modes when `en==1`:
  - 000 HOLD: `q` and `cnt` unchanged.
  - 001 LOAD: `q = d`, `cnt = 0`.
  - 010 SHL: `q = {q[WIDTH-2:0], sin_r}`.
  - 011 SHR: `q = {sin_l, q[WIDTH-1:1]}`.
  - 100 ROL: `q = {q[WIDTH-2:0], q[WIDTH-1]}`.
  - 101 ROR: `q = {q[0], q[WIDTH-1:1]}`.
  - 110 ASR: `q = {q[WIDTH-1], q[WIDTH-1:1]}`; `sin_l` is ignored.
  - 111 CLEAR: `q = RESET_VAL`, `cnt = 0`.
- Counter rules:
  - Each of SHL, SHR, ROL, ROR and ASR increments `cnt` by 1.
  - `cnt` saturates at WIDTH; further shifts keep `cnt == WIDTH` while `q` keeps shifting.
  - HOLD leaves `cnt` unchanged.
- `done` is computed from the next value of `cnt`, so it is valid in the same cycle that `cnt` reaches WIDTH.
- `mode` has no undefined encodings; all 8 are decoded.

## Timing
- One-cycle latency: `q`, `cnt` and `done` reflect the operation sampled at edge N immediately after edge N.
- `sout_l`/`sout_r` are combinational from `q`, with no additional latency.
- A new operation is accepted every cycle; there are no internal wait states.
- Reset mid-shift (reset low with `en=1`, `mode=SHL`) takes effect at that edge; the shift is discarded.
- When reset is released, the first edge with `reset==1` executes the current `mode` normally.
- LOAD and CLEAR issued in the cycle where `cnt == WIDTH-1` win: `cnt` goes to 0 and `done = 0`.
- Serial inputs `sin_l`/`sin_r` are sampled only on edges where their mode is active.

## Test plan
- Reset:
  - Stimulus: `WIDTH=8`, `RESET_VAL=8'hA5`; hold `reset=0` for 2 cycles with `en=1`, `mode=001`, `d=8'hFF`.
  - Required: `q=8'hA5`, `cnt=0`, `done=0`, `sout_l=1`, `sout_r=1`.
- Load then serialise out:
  - Stimulus: LOAD `d=8'hB4`, then 8× SHL with `sin_r=0`.
  - Required: `sout_l` sequence 1,0,1,1,0,1,0,0 (including the post-load value).
  - Required: `q=8'h00`, `cnt=8`, `done=1` after the 8th shift.
  - Required: a 9th SHL keeps `cnt=8`, `done=1`.
- Serial in:
  - Stimulus: CLEAR, then 8× SHR with `sin_l` = 1,1,0,0,1,0,1,0.
  - Required: `q=8'h53`, `done=1`.
- Rotate and arithmetic shift:
  - Stimulus: LOAD `8'h81`; ROL → ROR → ASR ×2.
  - Required: `q` = `8'h03`, `8'h81`, `8'hC0`, `8'hE0`; `cnt=4`.
- Enable gating:
  - Stimulus: LOAD `8'h3C`; then `en=0` for 3 cycles with `mode=010`; then `en=1` for one SHL with `sin_r=1`.
  - Required: `q` stays `8'h3C`, `cnt=0` during gating.
  - Required: after the enabled SHL, `q=8'h79`, `cnt=1`.
- Reset mid-operation:
  - Stimulus: after 5 SHLs, assert `reset=0` for one cycle with `mode=SHL`.
  - Required: `q=RESET_VAL`, `cnt=0`.
  - Required: next edge with `reset=1`, `mode=SHL` gives `cnt=1`.
